// File: rtl/ahb_master_arbiter_if.sv
// Command/response link between ahb_master_arbiter (master modport) and the
// AHB_Lite_master transfer port (slave modport).
interface ahb_master_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ERR_WIDTH  = 2
);
  logic [ADDR_WIDTH-1:0] ADDR_t_h;
  logic                  RW_t_h;
  logic                  TRANSFER_t_h;
  logic [DATA_WIDTH-1:0] WDATA_t_h;
  logic                  timeout;
  logic                  DONE_h_t;
  logic [ERR_WIDTH-1:0]  FAIL_h_t;
  logic [DATA_WIDTH-1:0] RDATA_h_t;

  modport master (
    output ADDR_t_h, RW_t_h, TRANSFER_t_h, WDATA_t_h, timeout,
    input  DONE_h_t, FAIL_h_t, RDATA_h_t
  );

  modport slave (
    input  ADDR_t_h, RW_t_h, TRANSFER_t_h, WDATA_t_h, timeout,
    output DONE_h_t, FAIL_h_t, RDATA_h_t
  );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Arbitrates NUM_REQ requesters onto one AHB_Lite_master port with a completion watchdog.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module ahb_master_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ERR_WIDTH   = 2,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ-1:0]            rw_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic [ERR_WIDTH-1:0]          fail_o,
  output logic                          busy_o,
  ahb_master_arbiter_if.master          ahb
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CAND_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(2 * TIMEOUT_CYC);
  // Pulse is registered, so it is launched one count early to be visible at TIMEOUT_CYC-1.
  localparam logic [CNT_W-1:0] TO_PULSE = CNT_W'(TIMEOUT_CYC - 2);
  localparam logic [CNT_W-1:0] TO_ABORT = CNT_W'(2 * TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  winner;
  logic              found;
  logic [CNT_W-1:0]  cnt;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    found  = |req_i;
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[IDX_W'(i)]) winner = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0]  rr_ptr;
  logic [CAND_W-1:0] cand;

  // Scan from rr_ptr upward, wrapping past NUM_REQ-1 (NUM_REQ need not be a power of two).
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + CAND_W'(k);
      if (cand >= CAND_W'(NUM_REQ)) cand = cand - CAND_W'(NUM_REQ);
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state            <= StIdle;
      grant            <= '0;
      cnt              <= '0;
      ack_o            <= '0;
      rdata_o          <= '0;
      fail_o           <= '0;
      ahb.ADDR_t_h     <= '0;
      ahb.RW_t_h       <= 1'b0;
      ahb.TRANSFER_t_h <= 1'b0;
      ahb.WDATA_t_h    <= '0;
      ahb.timeout      <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr           <= '0;
`endif
    end else begin
      ahb.TRANSFER_t_h <= 1'b0;
      ahb.timeout      <= 1'b0;
      ack_o            <= '0;
      rdata_o          <= '0;
      fail_o           <= '0;
      unique case (state)
        StIdle: begin
          if (found) begin
            grant         <= winner;
            ahb.ADDR_t_h  <= addr_arr[winner];
            ahb.RW_t_h    <= rw_i[winner];
            ahb.WDATA_t_h <= wdata_arr[winner];
            state         <= StIssue;
          end
        end
        StIssue: begin
          ahb.TRANSFER_t_h <= 1'b1;
          cnt              <= '0;
          state            <= StWait;
        end
        StWait: begin
          cnt <= cnt + 1'b1;
          // DONE has priority over both the watchdog pulse and the abort.
          if (ahb.DONE_h_t) begin
            ack_o   <= NUM_REQ'(1) << grant;
            rdata_o <= ahb.RDATA_h_t;
            fail_o  <= ahb.FAIL_h_t;
            state   <= StResp;
          end else if (cnt == TO_ABORT) begin
            ack_o  <= NUM_REQ'(1) << grant;
            fail_o <= '1;
            state  <= StResp;
          end else if (cnt == TO_PULSE) begin
            ahb.timeout <= 1'b1;
          end
        end
        StResp: begin
`ifndef ARB_FIXED_PRIO_EN
          rr_ptr <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
`endif
          state  <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign busy_o = (state != StIdle);

endmodule
